// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, default timing
// parameters and the parity helper used by both transmitter and receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RTS   = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4,
        ST_ACK   = 3'd5
    } ps2_state_e;

    localparam int RTS_CYCLES_DEF     = 10000;
    localparam int TIMEOUT_CYCLES_DEF = 2000000;
    localparam int FILT_LEN_DEF       = 8;

    // Parity bit that makes the total count of ones in {parity, data} odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Glitch filter for a slow open-collector PS/2 line: the level only changes
// after FILT_LEN identical samples; fall_tick pulses once per filtered 1->0.
module ps2_clk_filter
    import ps2_pkg::*;
#(
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_in,
    output logic level,
    output logic fall_tick
);

    logic [FILT_LEN-1:0] filt_q, filt_d;
    logic                level_q, level_d;
    logic                fall_q, fall_d;

    // Next-state: shift in the raw sample, update hysteresis level and edge.
    always_comb begin
        filt_d = {sample_in, filt_q[FILT_LEN-1:1]};
        if (&filt_q) begin
            level_d = 1'b1;
        end else if (~|filt_q) begin
            level_d = 1'b0;
        end else begin
            level_d = level_q;
        end
        fall_d = level_q & ~level_d;
    end

    // Filter state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q  <= '1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            filt_q  <= filt_d;
            level_q <= level_d;
            fall_q  <= fall_d;
        end
    end

    assign level     = level_q;
    assign fall_tick = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, start/data/parity/stop
// framing clocked by the device, acknowledge check and inter-edge watchdog.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int RTS_CYCLES     = RTS_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int FILT_LEN       = FILT_LEN_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       ack_err
);

    localparam int RTS_W = $clog2(RTS_CYCLES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_e       state_q, state_d;
    logic [8:0]       shift_q, shift_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [RTS_W-1:0] rts_cnt_q, rts_cnt_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic             c_oe_q, c_oe_d;
    logic             d_oe_q, d_oe_d;
    logic             idle_q, idle_d;
    logic             done_q, done_d;
    logic             ack_err_q, ack_err_d;

    logic fall_tick_s;
    logic c_level_unused;
    logic d_level_s;
    logic d_fall_unused;

    ps2_clk_filter #(.FILT_LEN(FILT_LEN)) u_cfilt (
        .clk       (clk),
        .reset     (reset),
        .sample_in (ps2c),
        .level     (c_level_unused),
        .fall_tick (fall_tick_s)
    );

    ps2_clk_filter #(.FILT_LEN(FILT_LEN)) u_dfilt (
        .clk       (clk),
        .reset     (reset),
        .sample_in (ps2d),
        .level     (d_level_s),
        .fall_tick (d_fall_unused)
    );

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        rts_cnt_d = rts_cnt_q;
        wdog_d    = wdog_q;
        c_oe_d    = c_oe_q;
        d_oe_d    = d_oe_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;

        case (state_q)
            ST_IDLE: begin
                // A request coinciding with the completion pulse is dropped.
                if (wr_ps2 && !done_q) begin
                    shift_d   = {odd_parity(din), din};
                    rts_cnt_d = RTS_W'(RTS_CYCLES - 1);
                    ack_err_d = 1'b0;
                    c_oe_d    = 1'b1;
                    d_oe_d    = 1'b1;
                    state_d   = ST_RTS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RTS: begin
                if (rts_cnt_q == '0) begin
                    c_oe_d  = 1'b0;
                    state_d = ST_START;
                end else begin
                    rts_cnt_d = rts_cnt_q - RTS_W'(1);
                end
            end
            ST_START: begin
                if (fall_tick_s) begin
                    bit_cnt_d = 4'd8;
                    d_oe_d    = ~shift_q[0];
                    state_d   = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (fall_tick_s) begin
                    if (bit_cnt_q == 4'd0) begin
                        d_oe_d  = 1'b0;
                        state_d = ST_STOP;
                    end else begin
                        shift_d   = {1'b0, shift_q[8:1]};
                        d_oe_d    = ~shift_q[1];
                        bit_cnt_d = bit_cnt_q - 4'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                if (fall_tick_s) begin
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_ACK: begin
                if (fall_tick_s) begin
                    ack_err_d = d_level_s;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_ACK;
                end
            end
            default: begin
                c_oe_d  = 1'b0;
                d_oe_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // Watchdog runs only while the device is expected to be clocking.
        if (state_q inside {ST_START, ST_DATA, ST_STOP, ST_ACK}) begin
            if (fall_tick_s) begin
                wdog_d = '0;
            end else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                wdog_d    = '0;
                c_oe_d    = 1'b0;
                d_oe_d    = 1'b0;
                done_d    = 1'b1;
                ack_err_d = 1'b1;
                state_d   = ST_IDLE;
            end else begin
                wdog_d = wdog_q + WD_W'(1);
            end
        end else begin
            wdog_d = '0;
        end

        idle_d = (state_d == ST_IDLE);
    end

    // Sequencer state and registered line enables / status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            rts_cnt_q <= '0;
            wdog_q    <= '0;
            c_oe_q    <= 1'b0;
            d_oe_q    <= 1'b0;
            idle_q    <= 1'b1;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            rts_cnt_q <= rts_cnt_d;
            wdog_q    <= wdog_d;
            c_oe_q    <= c_oe_d;
            d_oe_q    <= d_oe_d;
            idle_q    <= idle_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
        end
    end

    assign ps2c         = c_oe_q ? 1'b0 : 1'bz;
    assign ps2d         = d_oe_q ? 1'b0 : 1'bz;
    assign tx_idle      = idle_q;
    assign tx_done_tick = done_q;
    assign ack_err      = ack_err_q;

endmodule
